// File: rtl/palette_loader.sv
// Palette write engine: streams a linear colour gradient into the palette RAM over a
// valid/ready port. The final slot (in-set colour) is taken from a separately latched value.
module palette_loader #(
  parameter int unsigned RBG_SIZE   = 24,
  parameter int unsigned LUT_SIZE   = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(LUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [RBG_SIZE-1:0]   colour_start,
  input  logic [RBG_SIZE-1:0]   colour_end,
  input  logic [RBG_SIZE-1:0]   colour_in_set,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [RBG_SIZE-1:0]   wr_data
);

  typedef enum logic [1:0] {StIdle, StLatch, StWrite, StDone} state_e;

  // Product width: 9-bit signed delta times a non-negative (ADDR_WIDTH+1)-bit index.
  localparam int unsigned PW = ADDR_WIDTH + 10;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(LUT_SIZE - 1);

  function automatic logic [8:0] chan_delta(input logic [7:0] s, input logic [7:0] e);
    return {1'b0, e} - {1'b0, s};
  endfunction

  function automatic logic [7:0] grad_chan(input logic [7:0] s, input logic signed [8:0] d,
                                           input logic [ADDR_WIDTH-1:0] i);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shr;
    prod = PW'(d) * PW'($signed({1'b0, i}));
    shr  = prod >>> ADDR_WIDTH;
    return 8'(PW'(s) + shr);
  endfunction

  function automatic logic [23:0] grad_entry(input logic [23:0] s, input logic [26:0] d,
                                             input logic [ADDR_WIDTH-1:0] i);
    return {grad_chan(s[23:16], d[26:18], i),
            grad_chan(s[15:8],  d[17:9],  i),
            grad_chan(s[7:0],   d[8:0],   i)};
  endfunction

  state_e                state_q, state_d;
  logic [RBG_SIZE-1:0]   cs_q, cs_d;
  logic [RBG_SIZE-1:0]   ce_q, ce_d;
  logic [RBG_SIZE-1:0]   cin_q, cin_d;
  logic [26:0]           delta_q, delta_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [RBG_SIZE-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign addr_nxt = wr_addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    ce_d      = ce_q;
    cin_d     = cin_q;
    delta_d   = delta_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cs_d    = colour_start;
          ce_d    = colour_end;
          cin_d   = colour_in_set;
          busy_d  = 1'b1;
          state_d = StLatch;
        end
      end
      StLatch: begin
        delta_d   = {chan_delta(cs_q[23:16], ce_q[23:16]),
                     chan_delta(cs_q[15:8],  ce_q[15:8]),
                     chan_delta(cs_q[7:0],   ce_q[7:0])};
        wr_en_d   = 1'b1;
        wr_addr_d = '0;
        wr_data_d = cs_q;  // entry(0) is always the start colour
        state_d   = StWrite;
      end
      StWrite: begin
        if (wr_ready) begin
          if (wr_addr_q == LastIdx) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            wr_addr_d = addr_nxt;
            wr_data_d = (addr_nxt == LastIdx) ? cin_q : grad_entry(cs_q, delta_q, addr_nxt);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cs_q      <= '0;
      ce_q      <= '0;
      cin_q     <= '0;
      delta_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      ce_q      <= ce_d;
      cin_q     <= cin_d;
      delta_q   <= delta_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: gradient runs, backpressure, ignored starts,
// mid-run reset and latency, scored against an integer floor-division model.
module tb_palette_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] colour_start, colour_end, colour_in_set;
  logic        busy, done, wr_en, wr_ready;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;

  palette_loader #(
    .RBG_SIZE  (24),
    .LUT_SIZE  (256),
    .ADDR_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .colour_start (colour_start),
    .colour_end   (colour_end),
    .colour_in_set(colour_in_set),
    .busy         (busy),
    .done         (done),
    .wr_en        (wr_en),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: observes the write port at the negedge, when all signals are settled.
  logic [23:0] mem [256];
  int beat_total = 0, run_base = 0, order_err = 0, stall_err = 0, stall_cnt = 0;
  int done_total = 0, done_err = 0, last_done_beats = 0;
  bit prev_stall = 0, prev_done = 0;
  logic [7:0]  prev_addr = '0;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_stall && (!wr_en || wr_addr != prev_addr || wr_data != prev_data)) stall_err++;
    if (wr_en && wr_ready) begin
      mem[wr_addr] = wr_data;
      if (int'(wr_addr) != beat_total - run_base) order_err++;
      beat_total++;
    end
    prev_stall = wr_en && !wr_ready && rst_n;
    if (prev_stall) stall_cnt++;
    prev_addr = wr_addr;
    prev_data = wr_data;
    if (done) begin
      done_total++;
      last_done_beats = beat_total - run_base;
      if (prev_done) done_err++;
    end
    prev_done = done;
  end

  function automatic int exp_chan(input int s, input int e, input int i);
    int p, q;
    p = (e - s) * i;
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    return (s + q) & 8'hff;
  endfunction

  function automatic logic [23:0] exp_entry(input logic [23:0] s, input logic [23:0] e,
                                            input logic [23:0] ins, input int i);
    if (i == 255) return ins;
    return {8'(exp_chan(int'(s[23:16]), int'(e[23:16]), i)),
            8'(exp_chan(int'(s[15:8]),  int'(e[15:8]),  i)),
            8'(exp_chan(int'(s[7:0]),   int'(e[7:0]),   i))};
  endfunction

  function automatic int score(input logic [23:0] s, input logic [23:0] e, input logic [23:0] ins);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_entry(s, e, ins, i)) bad++;
    return bad;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // One palette run; mode 1 = random wr_ready, poke = extra starts mid-run and in DONE.
  task automatic run_pal(input logic [23:0] s, input logic [23:0] e, input logic [23:0] ins,
                         input int mode, input bit poke);
    int k;
    run_base      = beat_total;
    colour_start  = s;
    colour_end    = e;
    colour_in_set = ins;
    start         = 1'b1;
    tick();
    start         = 1'b0;
    colour_start  = 24'hA5A5A5;
    colour_end    = 24'h5A5A5A;
    colour_in_set = 24'h3C3C3C;
    k = 0;
    while (!done && k < 3000) begin
      wr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = poke && (k == 60);
      tick();
      k++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wr_ready = 1'b1;
    repeat (4) tick();
  endtask

  int d0, s0, e0, k;

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    wr_ready = 1'b1;
    colour_start = '0;
    colour_end = '0;
    colour_in_set = '0;
    repeat (3) tick();
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_data", {8'd0, wr_data}, 32'd0);

    // 1: ascending red ramp
    d0 = done_total; e0 = done_err; s0 = order_err;
    run_pal(24'h000000, 24'hFF0000, 24'h000000, 0, 1'b0);
    check("t1_addr0", {8'd0, mem[0]}, 32'h000000);
    check("t1_addr128", {8'd0, mem[128]}, 32'h7F0000);
    check("t1_addr254", {8'd0, mem[254]}, 32'hFD0000);
    check("t1_addr255", {8'd0, mem[255]}, 32'h000000);
    check("t1_beats", beat_total - run_base, 32'd256);
    check("t1_done_cnt", done_total - d0, 32'd1);
    check("t1_done_width", done_err - e0, 32'd0);
    check("t1_order", order_err - s0, 32'd0);
    check("t1_score", score(24'h000000, 24'hFF0000, 24'h000000), 32'd0);

    // 2: descending, signed floor
    run_pal(24'hFFFFFF, 24'h000000, 24'h123456, 0, 1'b0);
    check("t2_addr0", {8'd0, mem[0]}, 32'hFFFFFF);
    check("t2_addr1", {8'd0, mem[1]}, 32'hFEFEFE);
    check("t2_addr128", {8'd0, mem[128]}, 32'h7F7F7F);
    check("t2_addr255", {8'd0, mem[255]}, 32'h123456);
    check("t2_score", score(24'hFFFFFF, 24'h000000, 24'h123456), 32'd0);

    // 3: random backpressure
    d0 = done_total; e0 = stall_cnt; s0 = stall_err; k = order_err;
    run_pal(24'h000000, 24'hFF0000, 24'h000000, 1, 1'b0);
    check("t3_beats", beat_total - run_base, 32'd256);
    check("t3_done_after_last", last_done_beats, 32'd256);
    check("t3_done_cnt", done_total - d0, 32'd1);
    check("t3_stalls_seen", {31'd0, stall_cnt > e0}, 32'd1);
    check("t3_stall_stable", stall_err - s0, 32'd0);
    check("t3_order", order_err - k, 32'd0);
    check("t3_score", score(24'h000000, 24'hFF0000, 24'h000000), 32'd0);

    // 4: extra starts mid-run and in DONE are ignored, then a clean rerun
    d0 = done_total;
    run_pal(24'hFFFFFF, 24'h000000, 24'h123456, 0, 1'b1);
    check("t4_beats", beat_total - run_base, 32'd256);
    check("t4_done_cnt", done_total - d0, 32'd1);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    check("t4_idle_wr_en", {31'd0, wr_en}, 32'd0);
    run_pal(24'h102030, 24'hF0E0D0, 24'hABCDEF, 0, 1'b0);
    check("t4_addr0", {8'd0, mem[0]}, 32'h102030);
    check("t4_addr128", {8'd0, mem[128]}, 32'h808080);
    check("t4_addr255", {8'd0, mem[255]}, 32'hABCDEF);
    check("t4_score", score(24'h102030, 24'hF0E0D0, 24'hABCDEF), 32'd0);

    // 5: reset at beat 100 aborts without done
    d0 = done_total;
    run_base = beat_total;
    colour_start = 24'h000000; colour_end = 24'h00FF00; colour_in_set = 24'h111111;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while ((beat_total - run_base) < 100 && k < 1000) begin
      tick();
      k++;
    end
    check("t5_reached_100", {31'd0, k < 1000}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_wr_en", {31'd0, wr_en}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_no_done", done_total - d0, 32'd0);
    k = order_err;
    run_pal(24'h000000, 24'h00FF00, 24'h111111, 0, 1'b0);
    check("t5_rerun_beats", beat_total - run_base, 32'd256);
    check("t5_rerun_order", order_err - k, 32'd0);
    check("t5_rerun_score", score(24'h000000, 24'h00FF00, 24'h111111), 32'd0);

    // 6: latency
    colour_start = 24'h000000; colour_end = 24'hFFFFFF; colour_in_set = 24'h000000;
    start = 1'b1;
    tick();  // start edge E
    start = 1'b0;
    check("t6_wr_en_after_E", {31'd0, wr_en}, 32'd0);
    check("t6_busy_after_E", {31'd0, busy}, 32'd1);
    tick();  // E+1
    check("t6_wr_en_after_E1", {31'd0, wr_en}, 32'd1);
    check("t6_addr_after_E1", {24'd0, wr_addr}, 32'd0);
    k = 1;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    check("t6_done_edge", k, 32'd257);
    check("t6_busy_with_done", {31'd0, busy}, 32'd0);
    tick();
    check("t6_done_pulse", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
